// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache:
// controller state encoding, geometry derivations and address field helpers.
package dcache_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REFILL = 2'd1,
      ST_WRITE  = 2'd2
   } dc_state_t;

   function automatic int calc_tag_w(input int addr_w, input int index_w, input int offset_w);
      return addr_w - index_w - offset_w;
   endfunction

   function automatic int calc_lines(input int index_w);
      return 1 << index_w;
   endfunction

   function automatic int calc_words(input int offset_w);
      return 1 << offset_w;
   endfunction

   // Generic slice of an address held in a wide container; callers cast to the field width.
   function automatic logic [63:0] addr_field(input logic [63:0] addr, input int lsb, input int width);
      logic [63:0] mask;
      mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
      return (addr >> lsb) & mask;
   endfunction

   function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int addr_w,
                                            input int index_w, input int offset_w);
      return addr_field(addr, index_w + offset_w, calc_tag_w(addr_w, index_w, offset_w));
   endfunction

   function automatic logic [63:0] addr_index(input logic [63:0] addr, input int index_w,
                                              input int offset_w);
      return addr_field(addr, offset_w, index_w);
   endfunction

   function automatic logic [63:0] addr_offset(input logic [63:0] addr, input int offset_w);
      return addr_field(addr, 0, offset_w);
   endfunction

endpackage

// File: rtl/dcache_line_ram.sv
// Tag, valid and data storage for the cache: asynchronous read port, synchronous
// write ports, and valid bits cleared by synchronous reset.
module dcache_line_ram
   import dcache_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int TAG_W    = 8,
   parameter int INDEX_W  = 6,
   parameter int OFFSET_W = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [INDEX_W-1:0]  rd_index,
   input  logic [OFFSET_W-1:0] rd_offset,
   output logic                rd_valid,
   output logic [TAG_W-1:0]    rd_tag,
   output logic [DATA_W-1:0]   rd_data,
   input  logic                data_we,
   input  logic [INDEX_W-1:0]  data_index,
   input  logic [OFFSET_W-1:0] data_offset,
   input  logic [DATA_W-1:0]   data_wdata,
   input  logic                tag_we,
   input  logic [INDEX_W-1:0]  tag_index,
   input  logic [TAG_W-1:0]    tag_wdata
);

   localparam int LINES = calc_lines(INDEX_W);
   localparam int WORDS = calc_words(OFFSET_W);

   logic [LINES-1:0]  valid_bits;
   logic [TAG_W-1:0]  tag_mem  [LINES];
   logic [DATA_W-1:0] data_mem [LINES*WORDS];

   assign rd_valid = valid_bits[rd_index];
   assign rd_tag   = tag_mem[rd_index];
   assign rd_data  = data_mem[{rd_index, rd_offset}];

   // Reset wins over a tag write so a refill completing under reset never becomes valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_bits <= '0;
      end else if (tag_we) begin
         valid_bits[tag_index] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (tag_we) begin
         tag_mem[tag_index] <= tag_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (data_we) begin
         data_mem[{data_index, data_offset}] <= data_wdata;
      end
   end

endmodule

// File: rtl/dcache_dm_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache between the core's M stage
// and a word-wide handshaked memory, with saturating load hit/miss counters.
module dcache_dm_wt
   import dcache_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 16,
   parameter int INDEX_W  = 6,
   parameter int OFFSET_W = 2,
   parameter int CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic              core_rd_en,
   input  logic              core_wr_en,
   input  logic [DATA_W-1:0] core_wdata,
   output logic [DATA_W-1:0] core_rdata,
   output logic              core_stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   input  logic              perf_clr,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);

   localparam int TAG_W  = calc_tag_w(ADDR_W, INDEX_W, OFFSET_W);
   localparam int LINE_W = ADDR_W - OFFSET_W;

   dc_state_t             state, state_nxt;
   logic [OFFSET_W-1:0]   refill_cnt;
   logic [LINE_W-1:0]     line_base;
   logic [ADDR_W-1:0]     wr_addr_q;
   logic [DATA_W-1:0]     wr_data_q;
   logic                  refill_done_q;

   logic [ADDR_W-1:0]     lookup_addr;
   logic [TAG_W-1:0]      lookup_tag;
   logic [INDEX_W-1:0]    lookup_index;
   logic [OFFSET_W-1:0]   lookup_offset;
   logic                  ram_valid;
   logic [TAG_W-1:0]      ram_tag;
   logic [DATA_W-1:0]     ram_data;
   logic                  hit;

   logic                  data_we;
   logic [INDEX_W-1:0]    data_index;
   logic [OFFSET_W-1:0]   data_offset;
   logic [DATA_W-1:0]     data_wdata;
   logic                  tag_we;

   logic                  start_refill;
   logic                  start_write;
   logic                  cnt_inc;
   logic                  count_hit;

   // A pending store is looked up with its latched address; otherwise the live core address.
   assign lookup_addr   = (state == ST_WRITE) ? wr_addr_q : core_addr;
   assign lookup_tag    = TAG_W'(addr_tag(64'(lookup_addr), ADDR_W, INDEX_W, OFFSET_W));
   assign lookup_index  = INDEX_W'(addr_index(64'(lookup_addr), INDEX_W, OFFSET_W));
   assign lookup_offset = OFFSET_W'(addr_offset(64'(lookup_addr), OFFSET_W));
   assign hit           = ram_valid && (ram_tag == lookup_tag);

   dcache_line_ram #(
      .DATA_W   (DATA_W),
      .TAG_W    (TAG_W),
      .INDEX_W  (INDEX_W),
      .OFFSET_W (OFFSET_W)
   ) u_line_ram (
      .clk         (clk),
      .rst         (rst),
      .rd_index    (lookup_index),
      .rd_offset   (lookup_offset),
      .rd_valid    (ram_valid),
      .rd_tag      (ram_tag),
      .rd_data     (ram_data),
      .data_we     (data_we),
      .data_index  (data_index),
      .data_offset (data_offset),
      .data_wdata  (data_wdata),
      .tag_we      (tag_we),
      .tag_index   (line_base[INDEX_W-1:0]),
      .tag_wdata   (line_base[LINE_W-1:INDEX_W])
   );

   // Controller: decides stall, drives the memory handshake and steers RAM writes.
   always_comb begin
      state_nxt    = state;
      core_stall   = 1'b0;
      core_rdata   = '0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      data_we      = 1'b0;
      data_index   = lookup_index;
      data_offset  = lookup_offset;
      data_wdata   = wr_data_q;
      tag_we       = 1'b0;
      start_refill = 1'b0;
      start_write  = 1'b0;
      cnt_inc      = 1'b0;
      count_hit    = 1'b0;

      unique case (state)
         ST_IDLE: begin
            if (core_wr_en) begin
               core_stall  = 1'b1;
               start_write = 1'b1;
               state_nxt   = ST_WRITE;
            end else if (core_rd_en) begin
               if (hit) begin
                  core_rdata = ram_data;
                  count_hit  = ~refill_done_q;
               end else begin
                  core_stall   = 1'b1;
                  start_refill = 1'b1;
                  state_nxt    = ST_REFILL;
               end
            end
         end

         ST_REFILL: begin
            core_stall = 1'b1;
            mem_req    = 1'b1;
            mem_addr   = {line_base, refill_cnt};
            if (mem_ack) begin
               data_we     = 1'b1;
               data_index  = line_base[INDEX_W-1:0];
               data_offset = refill_cnt;
               data_wdata  = mem_rdata;
               cnt_inc     = 1'b1;
               if (refill_cnt == '1) begin
                  tag_we    = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end
         end

         ST_WRITE: begin
            core_stall = ~mem_ack;
            mem_req    = 1'b1;
            mem_we     = 1'b1;
            mem_addr   = wr_addr_q;
            mem_wdata  = wr_data_q;
            if (mem_ack) begin
               data_we   = hit;
               state_nxt = ST_IDLE;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, refill word counter and the latched request; latches are don't-care under reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         refill_cnt    <= '0;
         refill_done_q <= 1'b0;
      end else begin
         state         <= state_nxt;
         refill_done_q <= tag_we;
         if (start_refill) begin
            line_base  <= core_addr[ADDR_W-1:OFFSET_W];
            refill_cnt <= '0;
         end else if (cnt_inc) begin
            refill_cnt <= refill_cnt + 1'b1;
         end
         if (start_write) begin
            wr_addr_q <= core_addr;
            wr_data_q <= core_wdata;
         end
      end
   end

   // The load that retries after a refill is excluded from hits; its miss was already counted.
   always_ff @(posedge clk) begin
      if (rst || perf_clr) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (count_hit && (hit_cnt != '1)) begin
            hit_cnt <= hit_cnt + 1'b1;
         end
         if (start_refill && (miss_cnt != '1)) begin
            miss_cnt <= miss_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dcache_dm_wt.sv
// Self-checking bench for dcache_dm_wt: directed scenarios followed by a random
// load/store/idle mix compared against a flat memory image and a tag/valid model.
module tb_dcache_dm_wt;

   localparam int DATA_W      = 32;
   localparam int ADDR_W      = 16;
   localparam int INDEX_W     = 6;
   localparam int OFFSET_W    = 2;
   localparam int CNT_W       = 4;
   localparam int WORDS       = 4;
   localparam int CNT_MAX     = 15;
   localparam int STALL_LIMIT = 200;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [ADDR_W-1:0] core_addr = '0;
   logic              core_rd_en = 1'b0;
   logic              core_wr_en = 1'b0;
   logic [DATA_W-1:0] core_wdata = '0;
   logic [DATA_W-1:0] core_rdata;
   logic              core_stall;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic              mem_ack = 1'b0;
   logic              perf_clr = 1'b0;
   logic [CNT_W-1:0]  hit_cnt;
   logic [CNT_W-1:0]  miss_cnt;

   int errors = 0;
   int checks = 0;

   logic [DATA_W-1:0] mem_arr [0:65535];
   logic [DATA_W-1:0] ref_mem [0:65535];
   bit                m_valid [0:63];
   int                m_tag   [0:63];
   int                hit_exp  = 0;
   int                miss_exp = 0;

   int                ack_delay = 0;
   int                wait_cnt  = 0;
   int                ack_total = 0;
   int                wr_seen   = 0;
   logic [ADDR_W-1:0] last_wr_addr = '0;
   logic [DATA_W-1:0] last_wr_data = '0;
   logic [ADDR_W-1:0] rd_log [$];

   dcache_dm_wt #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .INDEX_W  (INDEX_W),
      .OFFSET_W (OFFSET_W),
      .CNT_W    (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .core_addr  (core_addr),
      .core_rd_en (core_rd_en),
      .core_wr_en (core_wr_en),
      .core_wdata (core_wdata),
      .core_rdata (core_rdata),
      .core_stall (core_stall),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack),
      .perf_clr   (perf_clr),
      .hit_cnt    (hit_cnt),
      .miss_cnt   (miss_cnt)
   );

   always #5 clk = ~clk;

   // Memory responder: acknowledges each requested word after ack_delay waiting cycles.
   always @(negedge clk) begin
      mem_ack = 1'b0;
      if (!mem_req) begin
         wait_cnt = 0;
      end else if (wait_cnt >= ack_delay) begin
         mem_ack   = 1'b1;
         wait_cnt  = 0;
         ack_total = ack_total + 1;
         if (mem_we) begin
            mem_arr[mem_addr] = mem_wdata;
            last_wr_addr      = mem_addr;
            last_wr_data      = mem_wdata;
            wr_seen           = wr_seen + 1;
         end else begin
            mem_rdata = mem_arr[mem_addr];
            rd_log.push_back(mem_addr);
         end
      end else begin
         wait_cnt = wait_cnt + 1;
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time expired before completion");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic int satInc(input int v);
      return (v >= CNT_MAX) ? CNT_MAX : v + 1;
   endfunction

   task automatic clearModel();
      for (int i = 0; i < 64; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = 0;
      end
      hit_exp  = 0;
      miss_exp = 0;
   endtask

   // Samples 2 time units after each falling edge until the core is released.
   task automatic waitNotStall(output int cycles);
      cycles = 0;
      #2;
      while (core_stall && cycles < STALL_LIMIT) begin
         @(negedge clk);
         #2;
         cycles = cycles + 1;
      end
      if (core_stall) checkOutput("stall_timeout", 64'(core_stall), 64'd0);
   endtask

   task automatic doReset();
      @(negedge clk);
      rst        = 1'b1;
      core_rd_en = 1'b0;
      core_wr_en = 1'b0;
      perf_clr   = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      clearModel();
   endtask

   task automatic doIdle();
      @(negedge clk);
      core_rd_en = 1'b0;
      core_wr_en = 1'b0;
      #2;
      checkOutput("idle_stall", 64'(core_stall), 64'd0);
      checkOutput("idle_rdata", 64'(core_rdata), 64'd0);
      checkOutput("idle_req", 64'(mem_req), 64'd0);
      checkOutput("hit_cnt", 64'(hit_cnt), 64'(hit_exp));
      checkOutput("miss_cnt", 64'(miss_cnt), 64'(miss_exp));
   endtask

   task automatic doLoad(input logic [ADDR_W-1:0] addr, input int delay);
      int cyc;
      int idx;
      int tg;
      bit exp_hit;
      idx       = int'(addr[7:2]);
      tg        = int'(addr[15:8]);
      exp_hit   = m_valid[idx] && (m_tag[idx] == tg);
      ack_delay = delay;
      @(negedge clk);
      core_rd_en = 1'b1;
      core_wr_en = 1'b0;
      core_addr  = addr;
      waitNotStall(cyc);
      checkOutput("ld_data", 64'(core_rdata), 64'(ref_mem[addr]));
      checkOutput("ld_cycles", 64'(cyc), exp_hit ? 64'd0 : 64'(1 + WORDS * (delay + 1)));
      if (exp_hit) begin
         hit_exp = satInc(hit_exp);
      end else begin
         miss_exp     = satInc(miss_exp);
         m_valid[idx] = 1'b1;
         m_tag[idx]   = tg;
      end
   endtask

   task automatic doStore(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                          input int delay);
      int cyc;
      int prev;
      prev      = wr_seen;
      ack_delay = delay;
      @(negedge clk);
      core_rd_en = 1'b0;
      core_wr_en = 1'b1;
      core_addr  = addr;
      core_wdata = data;
      waitNotStall(cyc);
      checkOutput("st_cycles", 64'(cyc), 64'(1 + delay));
      checkOutput("st_count", 64'(wr_seen - prev), 64'd1);
      checkOutput("st_addr", 64'(last_wr_addr), 64'(addr));
      checkOutput("st_data", 64'(last_wr_data), 64'(data));
      ref_mem[addr] = data;
   endtask

   task automatic doClear();
      @(negedge clk);
      core_rd_en = 1'b0;
      core_wr_en = 1'b0;
      perf_clr   = 1'b1;
      @(negedge clk);
      perf_clr = 1'b0;
      hit_exp  = 0;
      miss_exp = 0;
      #2;
      checkOutput("clr_hit_cnt", 64'(hit_cnt), 64'd0);
      checkOutput("clr_miss_cnt", 64'(miss_cnt), 64'd0);
   endtask

   // Reset lands after the second refill word has been acknowledged.
   task automatic resetMidRefill(input logic [ADDR_W-1:0] addr);
      int base;
      int guard;
      base      = ack_total;
      guard     = 0;
      ack_delay = 0;
      @(negedge clk);
      core_rd_en = 1'b1;
      core_wr_en = 1'b0;
      core_addr  = addr;
      do begin
         @(negedge clk);
         #2;
         guard = guard + 1;
      end while (ack_total < base + 2 && guard < STALL_LIMIT);
      checkOutput("rst_two_acks", 64'(ack_total - base >= 2), 64'd1);
      @(negedge clk);
      rst        = 1'b1;
      core_rd_en = 1'b0;
      @(negedge clk);
      #2;
      checkOutput("rst_req_drop", 64'(mem_req), 64'd0);
      rst = 1'b0;
      clearModel();
   endtask

   task automatic applyStimulus(input int n);
      int r;
      int d;
      logic [ADDR_W-1:0] addr;
      for (int i = 0; i < n; i++) begin
         r    = int'($urandom_range(0, 99));
         d    = int'($urandom_range(0, 2));
         addr = ADDR_W'(($urandom_range(0, 2) << 8) | ($urandom_range(14, 17) << 2)
                        | $urandom_range(0, 3));
         if (r < 55)      doLoad(addr, d);
         else if (r < 85) doStore(addr, $urandom, d);
         else if (r < 97) doIdle();
         else             doClear();
      end
      doIdle();
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) begin
         mem_arr[a] = 32'(a) * 32'h9E37_79B1 + 32'h0000_1357;
         ref_mem[a] = mem_arr[a];
      end
      for (int k = 0; k < 4; k++) begin
         mem_arr[16'h0040 + k] = 32'h0000_00A0 + 32'(k);
         ref_mem[16'h0040 + k] = 32'h0000_00A0 + 32'(k);
      end
      clearModel();

      doReset();
      doIdle();

      rd_log.delete();
      doLoad(16'h0040, 0);
      checkOutput("t1_nreads", 64'(rd_log.size()), 64'd4);
      for (int k = 0; k < 4 && k < rd_log.size(); k++) begin
         checkOutput("t1_rdaddr", 64'(rd_log[k]), 64'(16'h0040 + k));
      end
      doIdle();

      rd_log.delete();
      doLoad(16'h0042, 0);
      checkOutput("t2_nreads", 64'(rd_log.size()), 64'd0);
      doIdle();

      doStore(16'h0041, 32'hDEAD_BEEF, 2);
      doLoad(16'h0041, 0);

      doStore(16'h1041, 32'h1234_5678, 1);
      doLoad(16'h0041, 0);
      doIdle();

      doLoad(16'h1040, 1);
      doLoad(16'h0040, 0);
      doIdle();

      resetMidRefill(16'h2040);
      doIdle();
      doLoad(16'h0040, 0);
      doLoad(16'h2040, 0);
      doIdle();

      doClear();
      applyStimulus(400);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
